// File: rtl/ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_arbiter
// Desc     : round-robin AHB bus arbiter with burst-length and lock tracking
// Revision : 1.0 - initial release
// ============================================================================
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [3:0]             hmaster,
  output logic                   hmastlock
);

  localparam logic [1:0] c_trans_nonseq = 2'd2;
  localparam logic [1:0] c_trans_seq    = 2'd3;
  localparam logic [1:0] c_resp_error   = 2'd1;
  localparam logic [3:0] c_default_idx  = 4'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] c_one         = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [NUM_MASTERS-1:0] c_reset_grant = c_one << DEFAULT_MASTER;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [NUM_MASTERS-1:0]   r_grant;
  logic [NUM_MASTERS-1:0]   w_grant_nxt;
  logic [3:0]               r_master;
  logic                     r_mastlock;
  logic [4:0]               r_beats;
  logic [4:0]               w_beats_nxt;
  logic [3:0]               w_grant_idx;
  logic [3:0]               w_sel_idx;
  logic                     w_owner_lock;
  logic                     w_arb_en;

  assign w_owner_lock = |(hlock & r_grant);

  always_comb begin
    w_beats_nxt = r_beats;
    case (htrans)
      c_trans_nonseq: begin
        case (hburst)
          3'd2, 3'd3: w_beats_nxt = 5'd3;
          3'd4, 3'd5: w_beats_nxt = 5'd7;
          3'd6, 3'd7: w_beats_nxt = 5'd15;
          default:    w_beats_nxt = 5'd0;
        endcase
      end
      c_trans_seq: w_beats_nxt = (r_beats == 5'd0) ? 5'd0 : r_beats - 5'd1;
      default:     w_beats_nxt = r_beats;
    endcase
    // An error response abandons the burst regardless of transfer type
    if (hresp == c_resp_error) w_beats_nxt = 5'd0;
  end

  assign w_arb_en = hready && (w_beats_nxt == 5'd0) && !w_owner_lock;

  always_comb begin
    w_grant_idx = 4'd0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[i]) w_grant_idx = 4'(i);
    end
  end

  // Two descending passes: lowest requester at or below the owner first, then
  // lowest requester above the owner overrides, giving search order owner+1..owner.
  always_comb begin
    w_sel_idx = c_default_idx;
    for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
      if (hbusreq[j] && (4'(j) <= w_grant_idx)) w_sel_idx = 4'(j);
    end
    for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
      if (hbusreq[j] && (4'(j) > w_grant_idx)) w_sel_idx = 4'(j);
    end
    w_grant_nxt = c_one << w_sel_idx;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB: begin
        if (w_beats_nxt != 5'd0)  w_state_nxt = ST_BURST;
        else if (w_owner_lock)    w_state_nxt = ST_LOCKED;
      end
      ST_BURST: begin
        if (w_beats_nxt == 5'd0)  w_state_nxt = w_owner_lock ? ST_LOCKED : ST_ARB;
      end
      ST_LOCKED: begin
        if (!w_owner_lock && (w_beats_nxt == 5'd0)) w_state_nxt = ST_ARB;
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_grant    <= c_reset_grant;
      r_master   <= c_default_idx;
      r_mastlock <= 1'b0;
      r_beats    <= 5'd0;
      r_state    <= ST_ARB;
    end else if (hready) begin
      r_beats    <= w_beats_nxt;
      r_master   <= w_grant_idx;
      r_mastlock <= w_owner_lock;
      r_state    <= w_state_nxt;
      if (w_arb_en) r_grant <= w_grant_nxt;
    end
  end

  assign hgrant    = r_grant;
  assign hmaster   = r_master;
  assign hmastlock = r_mastlock;

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
`default_nettype none
// Testbench for ahb_arbiter: table of directed vectors plus stall and async-reset sequences.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE = 2'd0, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;
  localparam logic [1:0] OKAY = 2'd0, ERROR = 2'd1;

  logic       hclk = 1'b0;
  logic       hreset = 1'b1;
  logic [3:0] hbusreq = '0;
  logic [3:0] hlock = '0;
  logic [1:0] htrans = IDLE;
  logic [2:0] hburst = SINGLE;
  logic       hready = 1'b1;
  logic [1:0] hresp = OKAY;
  logic [3:0] hgrant;
  logic [3:0] hmaster;
  logic       hmastlock;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] busreq;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [1:0] resp;
    logic [3:0] grant;
    logic [3:0] master;
    logic       mlock;
  } vec_t;

  vec_t vecs[$];

  ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [3:0] m, input logic ml);
    check({tag, " hgrant"},    {4'd0, hgrant},    {4'd0, g});
    check({tag, " hmaster"},   {4'd0, hmaster},   {4'd0, m});
    check({tag, " hmastlock"}, {7'd0, hmastlock}, {7'd0, ml});
  endtask

  task automatic drive(input logic [3:0] br, input logic [3:0] lk, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy, input logic [1:0] rs);
    hbusreq = br; hlock = lk; htrans = tr; hburst = bu; hready = rdy; hresp = rs;
  endtask

  task automatic step(input string tag, input logic [3:0] g, input logic [3:0] m, input logic ml);
    @(posedge hclk);
    #1;
    check_out(tag, g, m, ml);
  endtask

  task automatic add(input logic [3:0] br, input logic [3:0] lk, input logic [1:0] tr,
                     input logic [2:0] bu, input logic rdy, input logic [1:0] rs,
                     input logic [3:0] g, input logic [3:0] m, input logic ml);
    vec_t v;
    v.busreq = br; v.lock = lk; v.trans = tr; v.burst = bu; v.ready = rdy; v.resp = rs;
    v.grant = g; v.master = m; v.mlock = ml;
    vecs.push_back(v);
  endtask

  task automatic do_reset(input string tag);
    drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    hreset = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    hreset = 1'b0;
    check_out(tag, 4'b0001, 4'd0, 1'b0);
  endtask

  initial begin
    // idle bus: default master held
    add(4'b0000, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0001, 4'd0, 0);
    add(4'b0000, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0001, 4'd0, 0);
    add(4'b0000, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0001, 4'd0, 0);
    // masters 1 and 2 requesting: rotation 1 then 2
    add(4'b0110, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0010, 4'd0, 0);
    add(4'b0110, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0100, 4'd1, 0);
    add(4'b0100, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0100, 4'd2, 0);
    add(4'b0000, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0001, 4'd2, 0);
    add(4'b0000, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0001, 4'd0, 0);
    // master 2 INCR4 with master 3 waiting
    add(4'b1100, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0100, 4'd0, 0);
    add(4'b1100, 4'b0000, NONSEQ, INCR4,  1, OKAY,  4'b0100, 4'd2, 0);
    add(4'b1100, 4'b0000, SEQ,    INCR4,  1, OKAY,  4'b0100, 4'd2, 0);
    add(4'b1100, 4'b0000, SEQ,    INCR4,  1, OKAY,  4'b0100, 4'd2, 0);
    add(4'b1100, 4'b0000, SEQ,    INCR4,  1, OKAY,  4'b1000, 4'd2, 0);
    add(4'b0000, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0001, 4'd3, 0);
    add(4'b0000, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0001, 4'd0, 0);
    // master 1 locked across three SINGLE transfers
    add(4'b1111, 4'b0010, IDLE,   SINGLE, 1, OKAY,  4'b0010, 4'd0, 0);
    add(4'b1111, 4'b0010, NONSEQ, SINGLE, 1, OKAY,  4'b0010, 4'd1, 1);
    add(4'b1111, 4'b0010, NONSEQ, SINGLE, 1, OKAY,  4'b0010, 4'd1, 1);
    add(4'b1111, 4'b0010, NONSEQ, SINGLE, 1, OKAY,  4'b0010, 4'd1, 1);
    add(4'b1111, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0100, 4'd1, 0);
    add(4'b1111, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b1000, 4'd2, 0);
    // ERROR on second beat of INCR8 hands the bus to master 0
    add(4'b0011, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0001, 4'd3, 0);
    add(4'b0011, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0010, 4'd0, 0);
    add(4'b0011, 4'b0000, NONSEQ, INCR8,  1, OKAY,  4'b0010, 4'd1, 0);
    add(4'b0011, 4'b0000, SEQ,    INCR8,  1, ERROR, 4'b0001, 4'd1, 0);
    add(4'b0000, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0001, 4'd0, 0);
    // hready low freezes the request from master 3
    add(4'b1000, 4'b0000, IDLE,   SINGLE, 0, OKAY,  4'b0001, 4'd0, 0);
    add(4'b1000, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b1000, 4'd0, 0);

    do_reset("reset");
    foreach (vecs[k]) begin
      drive(vecs[k].busreq, vecs[k].lock, vecs[k].trans, vecs[k].burst, vecs[k].ready, vecs[k].resp);
      step($sformatf("v%0d", k), vecs[k].grant, vecs[k].master, vecs[k].mlock);
    end

    // INCR4 with a two-cycle stall; stalled inputs carry an ERROR that must be ignored
    do_reset("reset2");
    drive(4'b1100, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY);  step("st0", 4'b0100, 4'd0, 1'b0);
    drive(4'b1100, 4'b0000, NONSEQ, INCR4,  1'b1, OKAY);  step("st1", 4'b0100, 4'd2, 1'b0);
    drive(4'b1100, 4'b0000, SEQ,    INCR4,  1'b1, OKAY);  step("st2", 4'b0100, 4'd2, 1'b0);
    drive(4'b1000, 4'b1111, NONSEQ, SINGLE, 1'b0, ERROR); step("st3", 4'b0100, 4'd2, 1'b0);
    drive(4'b1000, 4'b1111, NONSEQ, SINGLE, 1'b0, ERROR); step("st4", 4'b0100, 4'd2, 1'b0);
    drive(4'b1100, 4'b0000, SEQ,    INCR4,  1'b1, OKAY);  step("st5", 4'b0100, 4'd2, 1'b0);
    drive(4'b1100, 4'b0000, SEQ,    INCR4,  1'b1, OKAY);  step("st6", 4'b1000, 4'd2, 1'b0);

    // asynchronous reset in the middle of a locked INCR16
    do_reset("reset3");
    drive(4'b0010, 4'b0010, IDLE,   SINGLE, 1'b1, OKAY);  step("r0", 4'b0010, 4'd0, 1'b0);
    drive(4'b0010, 4'b0010, NONSEQ, INCR16, 1'b1, OKAY);  step("r1", 4'b0010, 4'd1, 1'b1);
    drive(4'b0010, 4'b0010, SEQ,    INCR16, 1'b1, OKAY);  step("r2", 4'b0010, 4'd1, 1'b1);
    #3;
    hreset = 1'b1;
    #1;
    check_out("async", 4'b0001, 4'd0, 1'b0);
    @(posedge hclk);
    #1;
    drive(4'b0010, 4'b0000, IDLE, SINGLE, 1'b0, OKAY);
    hreset = 1'b0;
    step("post0", 4'b0001, 4'd0, 1'b0);
    drive(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    step("post1", 4'b0010, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_MASTERS, default 4, the number of bus masters (2..16).
REQ-002 The module SHALL have parameter DEFAULT_MASTER, default 0, the master index granted when no master requests.
REQ-003 The module SHALL have these ports:
- hclk  input  1  bus clock; all state updates on the rising edge.
- hreset  input  1  reset; asynchronous, active-high.
- hbusreq  input  NUM_MASTERS  per-master bus request.
- hlock  input  NUM_MASTERS  per-master locked-transfer request.
- htrans  input  2  transfer type of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hburst  input  3  burst type of the current owner (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
- hready  input  1  bus ready; the transfer completes or the address is accepted when high.
- hresp  input  2  slave response (OKAY=0, ERROR=1; RETRY and SPLIT are treated as OKAY).
- hgrant  output  NUM_MASTERS  one-hot registered grant.
- hmaster  output  4  index of the master owning the address phase.
- hmastlock  output  1  the current address-phase transfer is locked.

Function
REQ-004 hgrant SHALL be one-hot at all times after reset.
REQ-005 hgrant SHALL change only on a rising edge where hready=1 and arbitration is enabled (REQ-009).
REQ-006 hmaster SHALL load the index of the set hgrant bit on every rising edge where hready=1, and hold otherwise.
REQ-007 hmastlock SHALL load hlock[granted index] on the same edges as hmaster, and hold otherwise.
REQ-008 The arbiter SHALL keep a burst counter beats_left (5 bits), updated only on edges with hready=1:
- htrans=NONSEQ with a fixed-length hburst: load the burst length minus 1 (WRAP4/INCR4 -> 3; WRAP8/INCR8 -> 7; WRAP16/INCR16 -> 15).
- NONSEQ with SINGLE or INCR: load 0.
- SEQ: decrement, saturating at 0.
- BUSY or IDLE: hold.
- hresp=ERROR: clear to 0; this overrides all other updates.
REQ-009 Arbitration SHALL be enabled on an edge iff hready=1, the value beats_left takes at that edge is 0, and hlock of the currently granted master is 0.
REQ-010 The arbiter SHALL use a three-state machine, updated on hready=1 edges:
- ARB (no burst in progress): -> BURST when the new beats_left is nonzero; -> LOCKED when the granted master's hlock=1.
- BURST: -> ARB when beats_left reaches 0 and hlock=0; -> LOCKED when beats_left reaches 0 and hlock=1.
- LOCKED: -> ARB when the granted master's hlock=0 and beats_left=0.
- Grant changes are permitted only on the ARB transition edge, per REQ-009.
REQ-011 Selection SHALL be round-robin:
- The search starts at (current granted index + 1) mod NUM_MASTERS and wraps.
- The first master with hbusreq=1 wins.
- If no master requests, DEFAULT_MASTER SHALL be granted.
- If only the current owner requests, it SHALL keep the grant.
REQ-012 Simultaneous requests SHALL be resolved solely by REQ-011; the same master SHALL NOT win twice in a row while another master requests, except during a burst or lock.
REQ-013 A grant change SHALL take effect on hmaster at the next hready=1 edge after hgrant changes, giving one handover cycle.
REQ-014 While hready=0, all registers SHALL hold and inputs other than hreset SHALL be ignored.
REQ-015 hbusreq deasserting mid-burst or under lock SHALL NOT release the grant before the REQ-009 conditions hold.

Reset
REQ-016 When hreset is asserted, the arbiter SHALL immediately, asynchronously and including mid-burst, set:
- hgrant = 1<<DEFAULT_MASTER
- hmaster = DEFAULT_MASTER
- hmastlock = 0
- beats_left = 0
- state = ARB
REQ-017 The first grant change after reset deasserts SHALL occur no earlier than the first rising edge with hready=1.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset release, no requests, hready=1 -> hgrant=4'b0001 and hmaster=0 held indefinitely.
- hbusreq=4'b0110, hready=1 from reset -> hgrant=4'b0010 after 1 edge; hmaster=1 after the next edge; next grant 4'b0100 once master 1 goes idle.
- Master 2 issues INCR4 (NONSEQ, 3xSEQ) with master 3 requesting -> hgrant stays 4'b0100 until the edge accepting the 4th beat, then becomes 4'b1000.
- INCR4 with hready=0 for 2 cycles mid-burst -> beats_left and hgrant frozen; handover delayed by exactly 2 cycles.
- Master 1 hlock=1 with hbusreq=4'b1111 across 3 SINGLE transfers -> hgrant=4'b0010 and hmastlock=1 throughout; rotation to master 2 after hlock drops.
- hresp=ERROR on the 2nd beat of INCR8 with master 0 requesting -> beats_left=0 and the grant moves to master 0 at that edge.
- hreset asserted mid-INCR16 -> outputs return to reset values without a clock edge.
